dmem_arbiter: RTL and testbench

Two-port arbiter and byte sequencer for the processor's byte-wide, 32-entry data memory. It shares the single memory port between requester 0 (processor load/store path) and requester 1 (debug/loader port). Each granted request is a full 32-bit big-endian word access, serialised as four byte beats. The block sits between the requesters and the data memory array; it owns the memory address, write-enable and write-data lines.

---
 rtl/dmem_arbiter_if.sv | 32 +++
 rtl/dmem_arbiter.sv | 104 ++++++++++
 tb/tb_dmem_arbiter.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: requester and memory signals of the two-port data memory arbiter.
interface dmem_arbiter_if #(parameter int ADDR_W = 5);
    logic              r0_req;
    logic              r0_we;
    logic [ADDR_W-1:0] r0_addr;
    logic [31:0]       r0_wdata;
    logic              r0_gnt;
    logic              r0_done;
    logic [31:0]       r0_rdata;
    logic              r1_req;
    logic              r1_we;
    logic [ADDR_W-1:0] r1_addr;
    logic [31:0]       r1_wdata;
    logic              r1_gnt;
    logic              r1_done;
    logic [31:0]       r1_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;
    logic              busy;

    modport slave (
        input  r0_req, r0_we, r0_addr, r0_wdata, r1_req, r1_we, r1_addr, r1_wdata, mem_rdata,
        output r0_gnt, r0_done, r0_rdata, r1_gnt, r1_done, r1_rdata, mem_addr, mem_we, mem_wdata, busy
    );

    modport master (
        output r0_req, r0_we, r0_addr, r0_wdata, r1_req, r1_we, r1_addr, r1_wdata, mem_rdata,
        input  r0_gnt, r0_done, r0_rdata, r1_gnt, r1_done, r1_rdata, mem_addr, mem_we, mem_wdata, busy
    );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter serialising 32-bit big-endian word accesses into byte beats.
module dmem_arbiter #(parameter int ADDR_W = 5) (
    input logic          clk_i,
    input logic          rst_i,
    dmem_arbiter_if.slave bus_io
);
    typedef enum logic [1:0] {IDLE, XFER, DONE} state_e;

    state_e            state_q;
    logic [1:0]        k_q;
    logic              last_q;
    logic              sel_q;
    logic              we_q;
    logic              busy_q;
    logic              done_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic              mem_we_q;
    logic [7:0]        mem_wdata_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rbuf_q;
    logic [31:0]       rdata0_q;
    logic [31:0]       rdata1_q;

    logic              pick_d;
    logic              we_d;
    logic [ADDR_W-1:0] addr_d;
    logic [31:0]       wdata_d;
    logic [31:0]       rbuf_d;

    // pick_d = 1 grants requester 1; on a tie the side not granted last wins
    always_comb begin
        pick_d  = bus_io.r1_req & (~bus_io.r0_req | ~last_q);
        we_d    = pick_d ? bus_io.r1_we : bus_io.r0_we;
        addr_d  = pick_d ? bus_io.r1_addr : bus_io.r0_addr;
        wdata_d = pick_d ? bus_io.r1_wdata : bus_io.r0_wdata;
        rbuf_d  = {rbuf_q[23:0], bus_io.mem_rdata};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            k_q         <= '0;
            last_q      <= 1'b1;
            sel_q       <= 1'b0;
            we_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            wdata_q     <= '0;
            rbuf_q      <= '0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
        end else begin
            case (state_q)
                IDLE: if (bus_io.r0_req | bus_io.r1_req) begin
                    state_q     <= XFER;
                    k_q         <= '0;
                    sel_q       <= pick_d;
                    last_q      <= pick_d;
                    we_q        <= we_d;
                    busy_q      <= 1'b1;
                    mem_addr_q  <= addr_d;
                    mem_we_q    <= we_d;
                    mem_wdata_q <= wdata_d[31:24];
                    wdata_q     <= {wdata_d[23:0], 8'h00};
                end
                // both the write word and the read buffer shift MSB-first, one byte per beat
                XFER: begin
                    rbuf_q      <= rbuf_d;
                    k_q         <= k_q + 2'd1;
                    mem_addr_q  <= mem_addr_q + ADDR_W'(1);
                    mem_wdata_q <= wdata_q[31:24];
                    wdata_q     <= {wdata_q[23:0], 8'h00};
                    if (k_q == 2'd3) begin
                        state_q  <= DONE;
                        mem_we_q <= 1'b0;
                        done_q   <= 1'b1;
                        if (!we_q && !sel_q) rdata0_q <= rbuf_d;
                        if (!we_q && sel_q) rdata1_q <= rbuf_d;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus_io.r0_gnt    = busy_q & ~sel_q;
    assign bus_io.r1_gnt    = busy_q & sel_q;
    assign bus_io.r0_done   = done_q & ~sel_q;
    assign bus_io.r1_done   = done_q & sel_q;
    assign bus_io.r0_rdata  = rdata0_q;
    assign bus_io.r1_rdata  = rdata1_q;
    assign bus_io.mem_addr  = mem_addr_q;
    assign bus_io.mem_we    = mem_we_q;
    assign bus_io.mem_wdata = mem_wdata_q;
    assign bus_io.busy      = busy_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed tests of dmem_arbiter against a transaction-level model and a byte memory.
module tb_dmem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(5)) bus();
    dmem_arbiter #(.ADDR_W(5)) dut (.clk_i(clk), .rst_i(rst), .bus_io(bus));

    logic [7:0] mem [32];
    assign bus.mem_rdata = mem[bus.mem_addr];
    always @(posedge clk) if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;

    int n_chk = 0;
    int n_pass = 0;
    int nd0 = 0;
    always @(negedge clk) if (bus.r0_done === 1'b1) nd0 <= nd0 + 1;

    // transaction model: one word access starts at edge s, beat d sits in cycle s+d, done at s+4
    logic [7:0]  mm [32];
    int          cyc = 0;
    int          s = 0;
    logic        act = 1'b0;
    logic        side = 1'b0;
    logic        last = 1'b1;
    logic        mwe = 1'b0;
    logic [4:0]  maddr = '0;
    logic [31:0] mwd = '0;
    logic [31:0] mr [2];
    logic        pk;
    assign pk = (bus.r0_req && bus.r1_req) ? !last : bus.r1_req;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            act   <= 1'b0;
            last  <= 1'b1;
            mr[0] <= '0;
            mr[1] <= '0;
        end else begin
            cyc <= cyc + 1;
            if (act && mwe && cyc >= s && cyc <= s + 3)
                mm[maddr + 5'(cyc - s)] <= mwd[31 - 8 * (cyc - s) -: 8];
            if (act && !mwe && cyc == s + 3)
                mr[side] <= {mm[maddr], mm[maddr + 5'd1], mm[maddr + 5'd2], mm[maddr + 5'd3]};
            if ((!act || cyc + 1 >= s + 6) && (bus.r0_req || bus.r1_req)) begin
                act   <= 1'b1;
                s     <= cyc + 1;
                side  <= pk;
                last  <= pk;
                mwe   <= pk ? bus.r1_we : bus.r0_we;
                maddr <= pk ? bus.r1_addr : bus.r0_addr;
                mwd   <= pk ? bus.r1_wdata : bus.r0_wdata;
            end
        end
    end

    initial begin
        mr[0] = '0;
        mr[1] = '0;
        forever begin
            int d;
            logic eb, bt, ok;
            logic [4:0] ea;
            logic [7:0] ew;
            @(negedge clk);
            d  = cyc - s;
            eb = act && !rst && d >= 0 && d <= 4;
            bt = eb && d <= 3;
            ea = rst ? 5'd0 : maddr + 5'(d);
            ew = rst ? 8'd0 : mwd[31 - 8 * (bt ? d : 0) -: 8];
            ok = bus.busy === eb && bus.r0_gnt === (eb && !side) && bus.r1_gnt === (eb && side)
                 && bus.r0_done === (eb && d == 4 && !side) && bus.r1_done === (eb && d == 4 && side)
                 && bus.mem_we === (bt && mwe) && bus.r0_rdata === mr[0] && bus.r1_rdata === mr[1];
            if ((rst || bt) && bus.mem_addr !== ea) ok = 1'b0;
            if ((rst || (bt && mwe)) && bus.mem_wdata !== ew) ok = 1'b0;
            for (int i = 0; i < 32; i++) if (mem[i] !== mm[i]) ok = 1'b0;
            n_chk++;
            if (ok) n_pass++;
            else $display("FAIL cycle %0d: busy=%b gnt=%b%b done=%b%b we=%b addr=%0d wd=%h rd0=%h rd1=%h expected busy=%b side=%b beat=%0d we=%b addr=%0d wd=%h rd0=%h rd1=%h",
                          cyc, bus.busy, bus.r0_gnt, bus.r1_gnt, bus.r0_done, bus.r1_done, bus.mem_we,
                          bus.mem_addr, bus.mem_wdata, bus.r0_rdata, bus.r1_rdata,
                          eb, side, d, bt && mwe, ea, ew, mr[0], mr[1]);
        end
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, got, exp);
    endtask

    task automatic run(input bit sd, input bit we, input logic [4:0] a, input logic [31:0] d, output int lat);
        bit got;
        got = 1'b0;
        lat = 0;
        @(posedge clk); #2;
        if (sd) begin
            bus.r1_we = we; bus.r1_addr = a; bus.r1_wdata = d; bus.r1_req = 1'b1;
        end else begin
            bus.r0_we = we; bus.r0_addr = a; bus.r0_wdata = d; bus.r0_req = 1'b1;
        end
        @(posedge clk);
        for (int i = 1; i <= 20 && !got; i++) begin
            @(negedge clk);
            if (sd ? bus.r1_done : bus.r0_done) begin got = 1'b1; lat = i; end
        end
        chk("run_done", 64'(got), 64'd1);
        @(posedge clk); #2;
        if (sd) bus.r1_req = 1'b0; else bus.r0_req = 1'b0;
    endtask

    initial begin
        int lat, nd, dc, bz;
        int t [3];
        logic [2:0] order;
        logic [7:0] b10, b11;
        bit got;
        bus.r0_req = 0; bus.r0_we = 0; bus.r0_addr = '0; bus.r0_wdata = '0;
        bus.r1_req = 0; bus.r1_we = 0; bus.r1_addr = '0; bus.r1_wdata = '0;
        for (int i = 0; i < 32; i++) begin
            mem[i] <= 8'(i * 7 + 3);
            mm[i]  <= 8'(i * 7 + 3);
        end
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        chk("reset_outs", 64'({bus.busy, bus.r0_gnt, bus.r1_gnt, bus.mem_we, bus.mem_addr, bus.mem_wdata}), 64'd0);

        run(0, 1, 5'd4, 32'hDEADBEEF, lat);
        chk("wr_latency", 64'(lat), 64'd5);
        chk("wr_bytes", 64'({mem[4], mem[5], mem[6], mem[7]}), 64'hDEADBEEF);
        run(0, 0, 5'd4, 32'h0, lat);
        chk("rd_word", 64'(bus.r0_rdata), 64'hDEADBEEF);

        run(1, 1, 5'd30, 32'h11223344, lat);
        chk("wrap_bytes", 64'({mem[30], mem[31], mem[0], mem[1]}), 64'h11223344);
        run(1, 0, 5'd30, 32'h0, lat);
        chk("wrap_rd", 64'(bus.r1_rdata), 64'h11223344);

        @(posedge clk); #2 rst = 1'b1;
        bus.r0_we = 0; bus.r0_addr = 5'd4; bus.r0_req = 1;
        bus.r1_we = 0; bus.r1_addr = 5'd30; bus.r1_req = 1;
        @(posedge clk); #2 rst = 1'b0;
        nd = 0;
        order = '0;
        t[0] = 0; t[1] = 0; t[2] = 0;
        for (int i = 0; i < 40 && nd < 3; i++) begin
            @(negedge clk);
            if (bus.r0_done || bus.r1_done) begin
                t[nd] = i;
                order[2 - nd] = bus.r1_done;
                nd++;
            end
        end
        @(posedge clk); #2;
        bus.r0_req = 0; bus.r1_req = 0;
        chk("tie_count", 64'(nd), 64'd3);
        chk("tie_order", 64'(order), 64'b010);
        chk("tie_gap1", 64'(t[1] - t[0]), 64'd6);
        chk("tie_gap2", 64'(t[2] - t[1]), 64'd6);
        chk("tie_rd0", 64'(bus.r0_rdata), 64'hDEADBEEF);
        chk("tie_rd1", 64'(bus.r1_rdata), 64'h11223344);
        repeat (6) @(posedge clk);

        b10 = mem[10];
        b11 = mem[11];
        dc = nd0;
        @(posedge clk); #2;
        bus.r0_we = 1; bus.r0_addr = 5'd8; bus.r0_wdata = 32'hAABBCCDD; bus.r0_req = 1;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_outs", 64'({bus.r0_gnt, bus.r1_gnt, bus.r0_done, bus.r1_done, bus.busy, bus.mem_we, bus.mem_addr, bus.mem_wdata}), 64'd0);
        chk("rst_mid_rdata", {bus.r0_rdata, bus.r1_rdata}, 64'd0);
        bus.r0_req = 0;
        @(posedge clk); #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        chk("rst_mid_written", 64'({mem[8], mem[9]}), 64'hAABB);
        chk("rst_mid_untouched", 64'({mem[10], mem[11]}), 64'({b10, b11}));
        chk("rst_mid_nodone", 64'(nd0), 64'(dc));

        dc = nd0;
        @(posedge clk); #2;
        bus.r0_we = 1; bus.r0_addr = 5'd12; bus.r0_wdata = 32'h01020304; bus.r0_req = 1;
        @(posedge clk);
        @(posedge clk); #2 bus.r0_req = 0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (bus.r0_done) got = 1'b1;
        end
        chk("drop_done", 64'(got), 64'd1);
        bz = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.busy) bz++;
        end
        chk("drop_bytes", 64'({mem[12], mem[13], mem[14], mem[15]}), 64'h01020304);
        chk("drop_no_restart", 64'(bz), 64'd0);
        chk("drop_one_done", 64'(nd0 - dc), 64'd1);

        run(1, 1, 5'd20, 32'h55667788, lat);
        run(0, 0, 5'd20, 32'h0, lat);
        chk("keep_rd_before", 64'(bus.r0_rdata), 64'h55667788);
        run(0, 1, 5'd24, 32'h99AABBCC, lat);
        chk("keep_rd_after", 64'(bus.r0_rdata), 64'h55667788);
        chk("keep_wr_bytes", 64'({mem[24], mem[25], mem[26], mem[27]}), 64'h99AABBCC);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
